// File: rtl/boot_loader.sv
// Boot loader: receives a framed byte stream, assembles big-endian 16-bit
// words, writes them into RAM from address 0 upward and holds the CPU in
// reset until a complete image with a matching XOR checksum has arrived.
// Frame: LEN_HI, LEN_LO, N x {D_HI, D_LO}, CSUM (XOR of the 2N data bytes).
module boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  load_req,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   // Largest image that fits in RAM, as a 17-bit value so it can be
   // compared against a full 16-bit length without overflow.
   localparam logic [16:0] LEN_MAX = 17'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      ST_LEN_HI  = 3'd0,
      ST_LEN_LO  = 3'd1,
      ST_DATA_HI = 3'd2,
      ST_DATA_LO = 3'd3,
      ST_WRITE   = 3'd4,
      ST_CSUM    = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             len_q, len_d;
   logic [16:0]             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [7:0]              csum_q, csum_d;
   logic                    rx_ready_q, rx_ready_d;
   logic                    write_en_q, write_en_d;
   logic                    cpu_hold_q, cpu_hold_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;

   logic                    accept_s;
   logic [15:0]             n_full_s;

   // Running checksum: one data byte folded into the accumulator.
   function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   assign accept_s = rx_valid && rx_ready_q;
   assign n_full_s = {len_q[15:8], rx_byte};

   // Next-state, datapath and counter updates for the frame parser.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      csum_d  = csum_q;
      case (state_q)
         ST_LEN_HI: begin
            if (accept_s) begin
               len_d[15:8] = rx_byte;
               state_d     = ST_LEN_LO;
            end else begin
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_LO: begin
            if (accept_s) begin
               len_d[7:0] = rx_byte;
               if ({1'b0, n_full_s} > LEN_MAX) begin
                  state_d = ST_ERROR;
               end else if (n_full_s == 16'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA_HI;
               end
            end else begin
               state_d = ST_LEN_LO;
            end
         end
         ST_DATA_HI: begin
            if (accept_s) begin
               data_d[DATA_WIDTH-1:DATA_WIDTH-8] = rx_byte;
               csum_d  = csum_fold(csum_q, rx_byte);
               state_d = ST_DATA_LO;
            end else begin
               state_d = ST_DATA_HI;
            end
         end
         ST_DATA_LO: begin
            if (accept_s) begin
               data_d[7:0] = rx_byte;
               csum_d  = csum_fold(csum_q, rx_byte);
               state_d = ST_WRITE;
            end else begin
               state_d = ST_DATA_LO;
            end
         end
         ST_WRITE: begin
            // The strobe is visible for this cycle; advance for the next word.
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q + 17'd1;
            if ((cnt_q + 17'd1) == {1'b0, len_q}) begin
               state_d = ST_CSUM;
            end else begin
               state_d = ST_DATA_HI;
            end
         end
         ST_CSUM: begin
            if (accept_s) begin
               if (rx_byte == csum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERROR;
               end
            end else begin
               state_d = ST_CSUM;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (load_req) begin
               state_d = ST_LEN_HI;
               len_d   = 16'd0;
               cnt_d   = 17'd0;
               addr_d  = {ADDR_WIDTH{1'b0}};
               csum_d  = 8'd0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_LEN_HI;
         end
      endcase
   end

   // Output values decoded from the next state so every output is a flop.
   always_comb begin
      rx_ready_d = 1'b0;
      write_en_d = 1'b0;
      cpu_hold_d = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      case (state_d)
         ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: begin
            rx_ready_d = 1'b1;
         end
         ST_WRITE: begin
            write_en_d = 1'b1;
         end
         ST_DONE: begin
            cpu_hold_d = 1'b0;
            done_d     = 1'b1;
         end
         ST_ERROR: begin
            error_d = 1'b1;
         end
         default: begin
            rx_ready_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_LEN_HI;
         len_q      <= 16'd0;
         cnt_q      <= 17'd0;
         addr_q     <= {ADDR_WIDTH{1'b0}};
         data_q     <= {DATA_WIDTH{1'b0}};
         csum_q     <= 8'd0;
         rx_ready_q <= 1'b1;
         write_en_q <= 1'b0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         csum_q     <= csum_d;
         rx_ready_q <= rx_ready_d;
         write_en_q <= write_en_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign rx_ready = rx_ready_q;
   assign write_en = write_en_q;
   assign addr     = addr_q;
   assign data_in  = data_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: randomized framed byte streams, a frame-position
// reference model compared against the DUT every cycle, a RAM scoreboard,
// and literal checks for the directed scenarios.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rx_ready;
   logic        load_req;
   logic        write_en;
   logic [9:0]  addr;
   logic [15:0] data_in;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .load_req(load_req), .write_en(write_en),
      .addr(addr), .data_in(data_in), .cpu_hold(cpu_hold), .done(done),
      .error(error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- RAM seen by the DUT's bus ----------------
   logic [15:0] ram [0:1023];
   int          wr_count = 0;

   always @(posedge clk) begin
      if (write_en === 1'b1) begin
         ram[addr] <= data_in;
         wr_count  <= wr_count + 1;
      end
   end

   // ---------------- reference model ----------------
   // Tracks how many frame bytes were taken, the decoded length, the XOR of
   // data bytes, whether a word is waiting to be strobed, and the outcome.
   bit          m_on = 1'b0;
   int          m_k, m_n, m_words, m_st;  // m_st: 0 loading, 1 done, 2 error
   bit          m_pend, m_fresh;
   logic [7:0]  m_x, m_hi;
   logic [15:0] m_pw;

   always @(posedge clk) begin
      if (reset === 1'b0) begin
         m_on = 1'b1; m_k = 0; m_n = 0; m_x = 8'h00; m_pend = 1'b0;
         m_st = 0; m_words = 0; m_fresh = 1'b1;
      end else if (m_on) begin
         if (m_st != 0) begin
            if (load_req) begin
               m_st = 0; m_k = 0; m_n = 0; m_x = 8'h00; m_words = 0;
            end
         end else if (m_pend) begin
            m_pend = 1'b0;
            m_words++;
         end else if (rx_valid) begin
            m_k++;
            m_fresh = 1'b0;
            if (m_k == 1) begin
               m_n = int'(rx_byte) * 256;
            end else if (m_k == 2) begin
               m_n += int'(rx_byte);
               if (m_n > 1024) m_st = 2;
            end else if (m_k <= 2 + 2 * m_n) begin
               m_x ^= rx_byte;
               if (m_k % 2 == 1) begin
                  m_hi = rx_byte;
               end else begin
                  m_pend = 1'b1;
                  m_pw   = {m_hi, rx_byte};
               end
            end else begin
               m_st = (rx_byte == m_x) ? 1 : 2;
            end
         end
      end
      #1;
      if (m_on) begin
         check("rx_ready", 32'(rx_ready), 32'(m_st == 0 && !m_pend));
         check("write_en", 32'(write_en), 32'(m_pend));
         check("addr",     32'(addr),     32'(m_words % 1024));
         check("done",     32'(done),     32'(m_st == 1));
         check("error",    32'(error),    32'(m_st == 2));
         check("cpu_hold", 32'(cpu_hold), 32'(m_st != 1));
         if (m_pend) check("data_in", 32'(data_in), 32'(m_pw));
         else if (m_fresh) check("data_in_rst", 32'(data_in), 32'h0);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [15:0] img [0:1023];

   function automatic logic [7:0] img_csum(input int n);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < n; i++) c = c ^ img[i][15:8] ^ img[i][7:0];
      return c;
   endfunction

   // Offer one byte until taken (called at a negedge), then idle 'gap' cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      ok = 1'b0;
      rx_byte  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         ok = rx_ready;
         @(negedge clk);
      end
      rx_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL byte_accept: got not-taken, expected taken (byte %0h)", b);
      end
      for (int i = 0; i < gap; i++) begin
         rx_byte = 8'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic send_image(input int n, input logic [7:0] cs, input int maxgap);
      logic [15:0] nl;
      nl = 16'(n);
      send_byte(nl[15:8], $urandom_range(0, maxgap));
      send_byte(nl[7:0],  $urandom_range(0, maxgap));
      for (int i = 0; i < n; i++) begin
         send_byte(img[i][15:8], $urandom_range(0, maxgap));
         send_byte(img[i][7:0],  $urandom_range(0, maxgap));
      end
      send_byte(cs, 0);
   endtask

   task automatic wait_end();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (done || error) seen = 1'b1;
         else @(negedge clk);
      end
      check("end_reached", 32'(seen), 32'h1);
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_ram(input int n);
      for (int i = 0; i < n; i++) check("ram_word", 32'(ram[i]), 32'(img[i]));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int base, n;
      bit bad;
      logic [7:0] cs;
      reset = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; load_req = 1'b0;
      @(negedge clk);
      check("rst_cpu_hold", 32'(cpu_hold), 32'h1);
      check("rst_done",     32'(done),     32'h0);
      check("rst_error",    32'(error),    32'h0);
      check("rst_write_en", 32'(write_en), 32'h0);
      check("rst_addr",     32'(addr),     32'h0);
      check("rst_data_in",  32'(data_in),  32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Reference image: XOR of 12 34 AB CD 00 E9 is 0xA9.
      img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h00E9;
      check("model_csum", 32'(img_csum(3)), 32'hA9);
      base = wr_count;
      send_image(3, 8'hA9, 0);
      check("t1_done_next", 32'(done), 32'h1);
      check("t1_hold_next", 32'(cpu_hold), 32'h0);
      wait_end();
      check("t1_ram0", 32'(ram[0]), 32'h1234);
      check("t1_ram1", 32'(ram[1]), 32'hABCD);
      check("t1_ram2", 32'(ram[2]), 32'h00E9);
      check("t1_writes", 32'(wr_count - base), 32'd3);

      // Bad checksum: words written, then error; reload with a good image.
      pulse_load();
      base = wr_count;
      send_image(3, 8'h6A, 0);
      wait_end();
      check("t2_error", 32'(error), 32'h1);
      check("t2_hold",  32'(cpu_hold), 32'h1);
      check("t2_done",  32'(done), 32'h0);
      check("t2_writes", 32'(wr_count - base), 32'd3);
      pulse_load();
      img[0] = 16'h0F0F; img[1] = 16'h5AA5;
      send_image(2, img_csum(2), 1);
      wait_end();
      check("t2_reload_done", 32'(done), 32'h1);
      check_ram(2);

      // Length 1025 is rejected straight after LEN_LO.
      pulse_load();
      base = wr_count;
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      check("t3_error", 32'(error), 32'h1);
      repeat (4) @(negedge clk);
      check("t3_writes", 32'(wr_count - base), 32'd0);

      // Empty image with zero checksum.
      pulse_load();
      base = wr_count;
      send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      check("t4_done", 32'(done), 32'h1);
      check("t4_addr", 32'(addr), 32'h0);
      check("t4_writes", 32'(wr_count - base), 32'd0);

      // Bytes offered in DONE (and alongside load_req) must not be consumed.
      rx_byte = 8'h77; rx_valid = 1'b1;
      repeat (2) @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0; rx_valid = 1'b0;

      // Random gapped frames, some with corrupted checksum.
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) img[i] = 16'($urandom);
         bad = ($urandom_range(0, 2) == 0);
         cs  = img_csum(n) ^ (bad ? 8'h5A : 8'h00);
         send_image(n, cs, 3);
         wait_end();
         check("rnd_done",  32'(done),  32'(!bad));
         check("rnd_error", 32'(error), 32'(bad));
         check_ram(n);
         pulse_load();
      end

      // Reset in the middle of a word, then a fresh frame from address 0.
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'hC3, 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("t6_hold",  32'(cpu_hold), 32'h1);
      check("t6_addr",  32'(addr), 32'h0);
      check("t6_data",  32'(data_in), 32'h0);
      check("t6_done",  32'(done), 32'h0);
      check("t6_error", 32'(error), 32'h0);
      img[0] = 16'hBEEF; img[1] = 16'hCAFE;
      send_image(2, img_csum(2), 2);
      wait_end();
      check("t6_done_after", 32'(done), 32'h1);
      check_ram(2);

      // Full-size image: address wraps back to 0 after the last word.
      pulse_load();
      base = wr_count;
      for (int i = 0; i < 1024; i++) img[i] = 16'($urandom);
      send_image(1024, img_csum(1024), 0);
      wait_end();
      check("t7_done", 32'(done), 32'h1);
      check("t7_addr_wrap", 32'(addr), 32'h0);
      check("t7_writes", 32'(wr_count - base), 32'd1024);
      check_ram(1024);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
